// File: rtl/dcache_pkg.sv
// Shared encodings, block geometry and address-field helpers for the write-back data cache.
package dcache_pkg;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITEBACK = 2'd1;
    localparam logic [1:0] S_ALLOCATE  = 2'd2;

    localparam int unsigned BLOCK_W         = 128;
    localparam int unsigned WORDS_PER_BLOCK = 4;
    localparam int unsigned WORD_W          = 32;

    // Line index: word address with the 2-bit word offset stripped, masked to idx_w bits
    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int unsigned idx_w);
        logic [31:0] mask;
        mask = (32'd1 << idx_w) - 32'd1;
        return (addr >> 2) & mask;
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int unsigned idx_w);
        return addr >> (idx_w + 32'd2);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage for the cache: valid/dirty/tag/data with a combinational read port and one write port.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int unsigned LINES = 8,
    parameter int unsigned IDX_W = 3,
    parameter int unsigned TAG_W = 25
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IDX_W-1:0]   idx,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [BLOCK_W-1:0] rd_line,
    input  logic               fill_en,
    input  logic [TAG_W-1:0]   fill_tag,
    input  logic [BLOCK_W-1:0] fill_line,
    input  logic               merge_en,
    input  logic [1:0]         merge_off,
    input  logic [WORD_W-1:0]  merge_word
);

    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   dirty_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [BLOCK_W-1:0] data_q [LINES];

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_line  = data_q[idx];

    // Only the state bits are reset; tag/data are qualified by valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (merge_en) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[idx]  <= fill_tag;
            data_q[idx] <= fill_line;
        end else if (merge_en) begin
            data_q[idx][{merge_off, 5'd0} +: WORD_W] <= merge_word;
        end
    end

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back/write-allocate data cache; stalls the pipeline during write-back and refill.
// Optional hit/miss/write-back counters are built when DCACHE_PERF_CNT_EN is defined.
module dcache_wb
    import dcache_pkg::*;
#(
    parameter int unsigned LINES  = 8,
    parameter int unsigned ADDR_W = 30
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                proc_read,
    input  logic                proc_write,
    input  logic [ADDR_W-1:0]   proc_addr,
    input  logic [WORD_W-1:0]   proc_wdata,
    output logic [WORD_W-1:0]   proc_rdata,
    output logic                proc_stall,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-3:0]   mem_addr,
    output logic [BLOCK_W-1:0]  mem_wdata,
    input  logic [BLOCK_W-1:0]  mem_rdata,
    input  logic                mem_ready
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]         hit_cnt,
    output logic [31:0]         miss_cnt,
    output logic [31:0]         wb_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = ADDR_W - 2 - IDX_W;

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic [1:0]         off;
    logic               req;
    logic               hit;
    logic               rd_valid;
    logic               rd_dirty;
    logic [TAG_W-1:0]   rd_tag;
    logic [BLOCK_W-1:0] rd_line;
    logic               fill_en;
    logic               merge_en;
    logic [1:0]         state;
    logic [1:0]         next_state;

    assign idx = IDX_W'(addr_index(32'(proc_addr), IDX_W));
    assign tag = TAG_W'(addr_tag(32'(proc_addr), IDX_W));
    assign off = proc_addr[1:0];
    assign req = proc_read | proc_write;
    assign hit = rd_valid & (rd_tag == tag);

    dcache_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .idx        (idx),
        .rd_valid   (rd_valid),
        .rd_dirty   (rd_dirty),
        .rd_tag     (rd_tag),
        .rd_line    (rd_line),
        .fill_en    (fill_en),
        .fill_tag   (tag),
        .fill_line  (mem_rdata),
        .merge_en   (merge_en),
        .merge_off  (off),
        .merge_word (proc_wdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      if (req && !hit) next_state = (rd_valid && rd_dirty) ? S_WRITEBACK : S_ALLOCATE;
            S_WRITEBACK: if (mem_ready) next_state = S_ALLOCATE;
            S_ALLOCATE:  if (mem_ready) next_state = S_IDLE;
            default:     next_state = S_IDLE;
        endcase
    end

    // Memory side is decoded from state; the stored line and held CPU address keep it stable
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        proc_stall = 1'b0;
        proc_rdata = '0;
        fill_en    = 1'b0;
        merge_en   = 1'b0;
        case (state)
            S_IDLE: begin
                proc_stall = req & ~hit;
                merge_en   = proc_write & hit;
                if (proc_read && !proc_write && hit)
                    proc_rdata = rd_line[{off, 5'd0} +: WORD_W];
            end
            S_WRITEBACK: begin
                mem_write  = 1'b1;
                mem_addr   = {rd_tag, idx};
                mem_wdata  = rd_line;
                proc_stall = 1'b1;
            end
            S_ALLOCATE: begin
                mem_read   = 1'b1;
                mem_addr   = proc_addr[ADDR_W-1:2];
                proc_stall = 1'b1;
                fill_en    = mem_ready;
            end
            default: ;
        endcase
    end

`ifdef DCACHE_PERF_CNT_EN
    // replay marks the first IDLE cycle after a refill so its hit is not counted
    logic replay;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            replay   <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            replay <= (state == S_ALLOCATE) && mem_ready;
            if ((state == S_IDLE) && req && hit && !replay && (hit_cnt != '1))
                hit_cnt <= hit_cnt + 32'd1;
            if ((state == S_IDLE) && req && !hit && (miss_cnt != '1))
                miss_cnt <= miss_cnt + 32'd1;
            if ((state == S_WRITEBACK) && mem_ready && (wb_cnt != '1))
                wb_cnt <= wb_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_wb.sv
// Randomized bench for dcache_wb against a line-level cache model and a block-memory model.
module tb_dcache_wb;

    logic         clk;
    logic         rst;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
    logic [31:0]  wb_cnt;
    int           exp_hits;
    int           exp_misses;
    int           exp_wbs;
`endif

    dcache_wb #(.LINES(8), .ADDR_W(30)) dut (
        .clk        (clk),
        .rst        (rst),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt),
        .wb_cnt     (wb_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each line remembers which memory block it holds
    bit           mv [8];
    bit           md [8];
    logic [27:0]  mb [8];
    logic [127:0] ml [8];
    logic [127:0] mem_m [logic [27:0]];

    int n_chk;
    int n_pass;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [127:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
        end
`ifdef DCACHE_PERF_CNT_EN
        exp_hits = 0;
        exp_misses = 0;
        exp_wbs = 0;
`endif
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        proc_read  = 1'b0;
        proc_write = 1'b0;
        mem_ready  = 1'($urandom_range(0, 1));
        mem_rdata  = rand_blk();
        #1;
        check("idle_rdata", proc_rdata, 0);
        check("idle_stall", proc_stall, 0);
        check("idle_mem_rw", {mem_read, mem_write}, 0);
        @(posedge clk);
    endtask

    task automatic access(input bit rd, input bit wr, input logic [29:0] a, input logic [31:0] wd,
                          input int lat, output int stalls);
        logic [27:0] blk;
        int          idx;
        int          off;
        bit          hit;
        blk    = a[29:2];
        idx    = int'(blk % 8);
        off    = int'(a[1:0]);
        hit    = mv[idx] && (mb[idx] == blk);
        stalls = 0;
        @(negedge clk);
        proc_read  = rd;
        proc_write = wr;
        proc_addr  = a;
        proc_wdata = wd;
        mem_ready  = 1'b0;
        #1;
        if (hit) begin
            check("hit_stall", proc_stall, 0);
            check("hit_mem_rw", {mem_read, mem_write}, 0);
            if (rd && !wr) check("hit_rdata", proc_rdata, ml[idx][off*32 +: 32]);
`ifdef DCACHE_PERF_CNT_EN
            exp_hits++;
`endif
        end else begin
            check("miss_stall", proc_stall, 1);
            stalls += int'(proc_stall);
`ifdef DCACHE_PERF_CNT_EN
            exp_misses++;
`endif
            @(posedge clk);
            if (mv[idx] && md[idx]) begin
                for (int c = 1; c <= lat; c++) begin
                    @(negedge clk);
                    mem_ready = (c == lat);
                    #1;
                    check("wb_rw", {mem_read, mem_write}, 2'b01);
                    check("wb_addr", mem_addr, mb[idx]);
                    check("wb_data", mem_wdata, ml[idx]);
                    check("wb_stall", proc_stall, 1);
                    stalls += int'(proc_stall);
                    @(posedge clk);
                end
                mem_m[mb[idx]] = ml[idx];
`ifdef DCACHE_PERF_CNT_EN
                exp_wbs++;
`endif
            end
            if (!mem_m.exists(blk)) mem_m[blk] = rand_blk();
            for (int c = 1; c <= lat; c++) begin
                @(negedge clk);
                mem_ready = (c == lat);
                mem_rdata = (c == lat) ? mem_m[blk] : rand_blk();
                #1;
                check("alloc_rw", {mem_read, mem_write}, 2'b10);
                check("alloc_addr", mem_addr, blk);
                check("alloc_stall", proc_stall, 1);
                stalls += int'(proc_stall);
                @(posedge clk);
            end
            mv[idx] = 1'b1;
            md[idx] = 1'b0;
            mb[idx] = blk;
            ml[idx] = mem_m[blk];
            @(negedge clk);
            mem_ready = 1'b0;
            mem_rdata = rand_blk();
            #1;
            check("replay_stall", proc_stall, 0);
            check("replay_mem_rw", {mem_read, mem_write}, 0);
            if (rd && !wr) check("replay_rdata", proc_rdata, ml[idx][off*32 +: 32]);
        end
        @(posedge clk);
        if (wr) begin
            ml[idx][off*32 +: 32] = wd;
            md[idx] = 1'b1;
        end
    endtask

    initial begin
        int st;
        n_chk      = 0;
        n_pass     = 0;
        rst        = 1'b0;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = '0;
        proc_wdata = '0;
        mem_rdata  = '0;
        mem_ready  = 1'b0;
        model_reset();
        #1;
        check("rst_mem_rw", {mem_read, mem_write}, 0);
        check("rst_stall", proc_stall, 0);
        check("rst_rdata", proc_rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Refill of block 4, memory answering on the fourth request cycle
        mem_m[28'h4] = 128'h44443333_22221111_BBBBAAAA_DDDDCCCC;
        access(1, 0, 30'h10, 32'h0, 4, st);
        check("t1_stall_cycles", st, 5);
        access(0, 1, 30'h10, 32'hDEADBEEF, 1, st);
        check("t2_write_stalls", st, 0);
        access(1, 0, 30'h10, 32'h0, 1, st);
        check("t2_read_stalls", st, 0);
        // Conflicting block forces write-back of the dirty line
        access(1, 0, 30'h30, 32'h0, 2, st);
        check("t3_stall_cycles", st, 5);
`ifdef DCACHE_PERF_CNT_EN
        check("t6_hit_cnt", hit_cnt, 2);
        check("t6_miss_cnt", miss_cnt, 2);
        check("t6_wb_cnt", wb_cnt, 1);
`endif

        // Reset while a refill is outstanding
        @(negedge clk);
        proc_read  = 1'b1;
        proc_write = 1'b0;
        proc_addr  = 30'h200;
        #1;
        check("t4_miss_stall", proc_stall, 1);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("t4_alloc_read", mem_read, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t4_rst_mem_rw", {mem_read, mem_write}, 0);
        model_reset();
`ifdef DCACHE_PERF_CNT_EN
        check("t4_rst_hit_cnt", hit_cnt, 0);
`endif
        proc_read = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        access(1, 0, 30'h200, 32'h0, 2, st);
        check("t4_remiss_stalls", st, 3);

        // Simultaneous read and write on a hit acts as a store
        access(1, 0, 30'h31, 32'h0, 1, st);
        access(1, 1, 30'h31, 32'hCAFEF00D, 1, st);
        check("t5_both_stalls", st, 0);
        access(1, 0, 30'h31, 32'h0, 1, st);
        access(1, 0, 30'h11, 32'h0, 3, st);
        check("t5_dirty_wb_stalls", st, 7);

        for (int i = 0; i < 400; i++) begin
            int mode;
            mode = int'($urandom_range(0, 9));
            if (mode < 2) idle_cycle();
            else access(mode != 3, mode >= 3 && mode <= 5, 30'($urandom_range(0, 255)),
                        $urandom, int'($urandom_range(1, 4)), st);
        end
`ifdef DCACHE_PERF_CNT_EN
        check("end_hit_cnt", hit_cnt, exp_hits);
        check("end_miss_cnt", miss_cnt, exp_misses);
        check("end_wb_cnt", wb_cnt, exp_wbs);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dcache_wb.md
Name: dcache_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache between the pipelined CPU's MEM stage (MEM_ADDRIN / MEM_WriteData / MEM_MemRead / MEM_MemWrite / MEM_ReadDataOUT) and slow external data memory.
- Serves hits combinationally with no stall.
- Freezes the whole pipeline through proc_stall while it writes back a dirty line and/or refills a line.
- Memory side moves one 4-word (128-bit) block per transaction with a ready handshake.

Parameters:
- LINES, 8, number of cache lines; power of two, 2..64.
- ADDR_W, 30, CPU word-address width (byte address bits [31:2]).
- Derived: IDX_W = log2(LINES); TAG_W = ADDR_W - 2 - IDX_W; block address width ADDR_W-2.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- proc_read  in  1  CPU load request (driven from MEM_MemRead)
- proc_write  in  1  CPU store request (MEM_MemWrite)
- proc_addr  in  ADDR_W  CPU word address
- proc_wdata  in  32  store data
- proc_rdata  out  32  load data
- proc_stall  out  1  freeze all pipeline registers while high
- mem_read  out  1  block read request
- mem_write  out  1  block write request
- mem_addr  out  ADDR_W-2  block address
- mem_wdata  out  128  block write data; word 0 in bits [31:0]
- mem_rdata  in  128  block read data
- mem_ready  in  1  one-cycle pulse: transaction complete / rdata valid

Behaviour:
- Address split: word offset = proc_addr[1:0]; index = proc_addr[IDX_W+1:2]; tag = upper TAG_W bits.
- Per-line storage: valid, dirty, tag, 4x32 data.
- Reset (rst low, async):
  - all valid and dirty bits cleared; data and tag storage not reset;
  - state IDLE;
  - mem_read = mem_write = 0, proc_stall = 0, proc_rdata = 0, mem_addr = 0, mem_wdata = 0.
  - Reset mid-transaction aborts it; mem_read/mem_write drop immediately.
- Request = proc_read | proc_write. If both are high, the cycle is a write (write priority).
- hit = valid[idx] & (tag[idx] == tag).
- FSM states: IDLE, WRITEBACK, ALLOCATE. Outputs are Moore-decoded from state, except proc_stall and proc_rdata.
- IDLE:
  - proc_stall = request & ~hit.
  - Read hit: proc_rdata = selected word, same cycle, combinational.
  - Write hit: at the clock edge, the word is written and dirty[idx] is set.
  - No request: proc_rdata = 0; no state change.
  - Miss with ~(valid & dirty) -> ALLOCATE.
  - Miss with valid & dirty -> WRITEBACK.
- WRITEBACK:
  - mem_write = 1; mem_addr = {old tag, idx}; mem_wdata = stored line.
  - Held constant until mem_ready sampled high, then -> ALLOCATE.
  - proc_stall = 1.
- ALLOCATE:
  - mem_read = 1; mem_addr = proc_addr[ADDR_W-1:2]. Held until mem_ready.
  - On mem_ready: line = mem_rdata, tag written, valid = 1, dirty = 0; -> IDLE.
  - proc_stall = 1.
- After refill, IDLE re-evaluates. The request is now a hit, so the load returns or the store merges (and sets dirty) in the first IDLE cycle.
  - Clean miss cost = 1 + N_mem + 1 cycles, where N_mem = cycles until mem_ready.
  - Dirty miss adds the write-back latency.
- mem_ready is ignored in IDLE. mem_read and mem_write are never high together. WRITEBACK -> ALLOCATE swaps them in one cycle.
- The CPU holds proc_* stable while proc_stall is high; the cache relies on this.

Optional Feature:
- Macro: DCACHE_PERF_CNT_EN.
- Defined:
  - Adds outputs hit_cnt[31:0], miss_cnt[31:0], wb_cnt[31:0], all cleared by rst.
  - hit_cnt increments on an IDLE request that hits on its first evaluation cycle.
  - miss_cnt increments on each IDLE->WRITEBACK or IDLE->ALLOCATE transition.
  - wb_cnt increments on each WRITEBACK completion.
  - All three counters saturate at 0xFFFFFFFF.
  - The post-refill replay hit is not counted as a hit.
- Undefined: the ports and logic are absent; the behaviour above is otherwise identical.

Decomposition:
- Package dcache_pkg holds:
  - state encoding localparams S_IDLE = 2'd0, S_WRITEBACK = 2'd1, S_ALLOCATE = 2'd2;
  - BLOCK_W = 128 and WORDS_PER_BLOCK = 4;
  - functions for the tag/index field split.
- One sub-module, dcache_array: valid/dirty/tag/data storage with a combinational read port and one write port (full-line refill or single-word merge). The FSM, hit compare and muxing stay in dcache_wb.

Test Plan:
1. Reset, then read addr 0x10 with memory returning 0x44443333_22221111_... after 3 cycles -> mem_read high with mem_addr = 0x4; proc_stall high for 5 cycles; proc_rdata = word 0 of the returned block; no mem_write.
2. Write 0xDEADBEEF to 0x10 after test 1, then read 0x10 -> write takes no stall and no memory activity; read returns 0xDEADBEEF in the same cycle.
3. Read 0x30 (same index as 0x10, different tag; LINES = 8) while line 0x10 is dirty -> WRITEBACK with mem_addr = 0x4 and mem_wdata containing 0xDEADBEEF; then ALLOCATE with mem_addr = 0xC; final data from the 0x30 block.
4. Assert rst low during ALLOCATE with mem_ready never arriving -> mem_read low immediately; after release, a read of the same address misses again.
5. Assert proc_read and proc_write together on a hit -> treated as a write; dirty set; stored word updated.
6. With DCACHE_PERF_CNT_EN defined, run tests 1 to 3 -> hit_cnt = 2, miss_cnt = 2, wb_cnt = 1.
